countdown_alarm_timer: RTL and testbench
========================================

Name: countdown_alarm_timer

Overview:
Parametrised countdown timer with alarm. Loads a seconds count, decrements once per second while running, supports pause, resume, reload and abort. On reaching zero it enters an alarm state: a bouncing two-LED sweep drives the LED bank until the alarm is acknowledged or auto-silenced. Sits between the board switches/buttons and the LED bank in the top level, replacing the fixed 10-second countdown plus separate sweep logic.

Parameters:
CLKS_PER_SEC, 100000000, clk_100mhz cycles per one-second tick
CNT_W, 16, width of the seconds counter and load value
N_LEDS, 8, LED bank width (must be >= 3)
SWEEP_CLKS, 16777216, clock cycles per sweep step
ALARM_SECS, 30, alarm auto-silence time in seconds; 0 = never auto-silence

Ports:
clk_100mhz  in  1  system clock; the only clock
rst_n  in  1  synchronous, active-low reset
load  in  1  level-sampled each cycle: capture load_val into remaining
load_val  in  CNT_W  countdown start value, in seconds
start  in  1  start or resume counting
pause  in  1  pause counting
ack  in  1  abort a run or silence the alarm
alarm_en  in  1  LED output enable (switch); 0 blanks led
remaining  out  CNT_W  seconds left
running  out  1  high in RUN
alarm  out  1  high in ALARM
done_pulse  out  1  one-cycle pulse on entry to ALARM
led  out  N_LEDS  sweep pattern

Behaviour:
- Reset: when rst_n=0 at a clk_100mhz edge, go to IDLE. remaining=0, running=0, alarm=0, done_pulse=0, led=0, and all internal counters are 0.
- All outputs are registered.
- States: IDLE, RUN, PAUSED, ALARM.
- Second counter sec_cnt runs 0..CLKS_PER_SEC-1 and only advances in RUN.
  - tick = RUN and sec_cnt==CLKS_PER_SEC-1. sec_cnt wraps to 0 on tick.
  - sec_cnt is held in PAUSED.
  - sec_cnt is cleared on entry to RUN from IDLE and on any load.
- Same-cycle command priority: ack > load > pause > start.
- IDLE:
  - load: remaining<=load_val.
  - start with remaining!=0: go to RUN.
  - start with remaining==0: ignored.
- RUN:
  - tick with remaining==1: remaining<=0, go to ALARM, done_pulse=1 for that one cycle.
  - tick otherwise: remaining<=remaining-1.
  - load: remaining<=load_val, sec_cnt<=0, stay in RUN. Any same-cycle tick is discarded. load_val==0 goes to IDLE.
  - pause: go to PAUSED. A same-cycle tick still decrements; if that tick was the final one, go to ALARM.
  - ack: go to IDLE, remaining<=0.
- PAUSED:
  - start: go to RUN.
  - load: remaining<=load_val, stay in PAUSED.
  - ack: go to IDLE, remaining<=0.
- ALARM:
  - load, start and pause are ignored.
  - ack: go to IDLE.
  - If ALARM_SECS!=0: an independent alarm-seconds counter returns to IDLE after ALARM_SECS*CLKS_PER_SEC cycles in ALARM.
- Sweep:
  - Window of two adjacent lit LEDs.
  - On ALARM entry: led[N_LEDS-1:N_LEDS-2] lit, moving toward bit 0.
  - Shifts one position every SWEEP_CLKS cycles and reverses at each end. Full period = 2*(N_LEDS-2) steps.
  - The sweep keeps advancing while alarm_en=0.
  - led = window when ALARM and alarm_en=1; otherwise led = 0.
- Wrap-around: remaining never underflows; a value of 0 cannot be in RUN.

Decomposition:
- Package countdown_alarm_pkg holds:
  - the state encoding (IDLE, RUN, PAUSED, ALARM);
  - a helper constant for the sec_cnt width, $clog2(CLKS_PER_SEC).
- One sub-module, led_sweeper:
  - ports: clk_100mhz, rst_n, en (=ALARM), restart (=ALARM entry), led;
  - parameters: N_LEDS, SWEEP_CLKS.

Test Plan:
Bench parameters: CLKS_PER_SEC=4, SWEEP_CLKS=2, N_LEDS=8, ALARM_SECS=3, CNT_W=8. RUN is entered at edge k.
1. load 3, then start -> remaining=2 at k+4, 1 at k+8, 0 at k+12; alarm=1 and done_pulse=1 at k+12 only; running=0 from k+12.
2. load 3, start, pause at k+6, hold 10 cycles, then start -> remaining stays 2 while paused; remaining=1 exactly 2 cycles after RUN re-entry.
3. In ALARM with alarm_en=1 -> led = 0xC0, 0x60, 0x30, 0x18, 0x0C, 0x06, 0x03, 0x06, 0x0C..., each held 2 cycles; with alarm_en=0 -> led=0x00 while alarm stays 1.
4. In ALARM with no ack -> alarm drops after 12 cycles; state IDLE, led=0; ack in a later ALARM drops alarm on the next edge.
5. In RUN, ack+load+start asserted in the same cycle -> IDLE, remaining=0; a subsequent start with remaining=0 does not set running.
6. rst_n=0 for one cycle mid-ALARM -> every output 0 at that edge; load 5, start -> normal countdown from 5.

Source files
------------

// File: rtl/countdown_alarm_pkg.sv
// ---------------------------------------------------------------------------
// countdown_alarm_pkg
// Shared definitions for the countdown alarm timer:
//   - FSM state encoding (IDLE, RUN, PAUSED, ALARM)
//   - width helper used to size the one-second prescaler and other counters
// No ports (package).
// ---------------------------------------------------------------------------
package countdown_alarm_pkg;

    localparam int STATE_W = 2;

    localparam logic [STATE_W-1:0] ST_IDLE   = 2'd0;
    localparam logic [STATE_W-1:0] ST_RUN    = 2'd1;
    localparam logic [STATE_W-1:0] ST_PAUSED = 2'd2;
    localparam logic [STATE_W-1:0] ST_ALARM  = 2'd3;

    // Default board clock rate and the matching prescaler width.
    localparam int DEF_CLKS_PER_SEC = 100000000;
    localparam int DEF_SEC_W        = $clog2(DEF_CLKS_PER_SEC);

    // Width of a counter running 0..n-1; never narrower than one bit so
    // degenerate parameter values (n <= 1) still elaborate.
    function automatic int cnt_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/countdown_alarm_timer_led_sweeper.sv
// ---------------------------------------------------------------------------
// led_sweeper
// Bouncing two-LED window for the alarm display. On restart the window sits
// on the two top LEDs and moves toward bit 0, shifting one position every
// SWEEP_CLKS cycles and reversing at either end.
//
// Ports:
//   clk_100mhz  in   system clock
//   rst_n       in   synchronous active-low reset
//   en          in   sweep advances while high; position is cleared when low
//   restart     in   put the window back on the top two LEDs
//   show        in   drive the window onto led (0 blanks led, sweep continues)
//   led         out  registered LED pattern
// ---------------------------------------------------------------------------
module led_sweeper
    import countdown_alarm_pkg::*;
#(
    parameter int N_LEDS     = 8,
    parameter int SWEEP_CLKS = 16777216
) (
    input  logic              clk_100mhz,
    input  logic              rst_n,
    input  logic              en,
    input  logic              restart,
    input  logic              show,
    output logic [N_LEDS-1:0] led
);

    localparam int POS_W  = cnt_w(N_LEDS);
    localparam int STEP_W = cnt_w(SWEEP_CLKS);

    // pos is the index of the lower of the two lit LEDs: 0..N_LEDS-2
    localparam logic [POS_W-1:0]  POS_TOP   = POS_W'(N_LEDS - 2);
    localparam logic [STEP_W-1:0] STEP_LAST = STEP_W'(SWEEP_CLKS - 1);

    logic [POS_W-1:0]  pos_q,  pos_d;
    logic              down_q, down_d;
    logic [STEP_W-1:0] step_q, step_d;
    logic [N_LEDS-1:0] led_q,  led_d;

    function automatic logic [N_LEDS-1:0] window(input logic [POS_W-1:0] p);
        logic [N_LEDS-1:0] w;
        w = {{(N_LEDS-2){1'b0}}, 2'b11};
        return w << p;
    endfunction

    always_comb begin
        pos_d  = pos_q;
        down_d = down_q;
        step_d = step_q;
        led_d  = '0;

        if (restart) begin
            pos_d  = POS_TOP;
            down_d = 1'b1;
            step_d = '0;
        end else if (en) begin
            if (step_q == STEP_LAST) begin
                step_d = '0;
                // Direction flips on the step that lands on an end position,
                // so each end LED pair is shown exactly once per pass.
                if (down_q) begin
                    pos_d = pos_q - 1'b1;
                    if (pos_q == POS_W'(1)) begin
                        down_d = 1'b0;
                    end
                end else begin
                    pos_d = pos_q + 1'b1;
                    if (pos_q == POS_TOP - 1'b1) begin
                        down_d = 1'b1;
                    end
                end
            end else begin
                step_d = step_q + 1'b1;
            end
        end else begin
            pos_d  = '0;
            down_d = 1'b0;
            step_d = '0;
        end

        // led is registered from the next position so it lines up with
        // the registered state outputs of the timer.
        if ((restart || en) && show) begin
            led_d = window(pos_d);
        end
    end

    always_ff @(posedge clk_100mhz) begin
        if (!rst_n) begin
            pos_q  <= '0;
            down_q <= 1'b0;
            step_q <= '0;
            led_q  <= '0;
        end else begin
            pos_q  <= pos_d;
            down_q <= down_d;
            step_q <= step_d;
            led_q  <= led_d;
        end
    end

    assign led = led_q;

endmodule

// File: rtl/countdown_alarm_timer.sv
// ---------------------------------------------------------------------------
// countdown_alarm_timer
// Loadable seconds countdown with pause/resume/reload/abort. Reaching zero
// enters ALARM, which drives a bouncing LED sweep until ack or until the
// optional auto-silence time expires.
//
// Ports:
//   clk_100mhz  in   system clock (only clock)
//   rst_n       in   synchronous active-low reset
//   load        in   capture load_val into remaining (level, every cycle)
//   load_val    in   countdown start value in seconds
//   start       in   start or resume counting
//   pause       in   pause counting
//   ack         in   abort a run or silence the alarm
//   alarm_en    in   LED enable; 0 blanks led
//   remaining   out  seconds left
//   running     out  high in RUN
//   alarm       out  high in ALARM
//   done_pulse  out  one-cycle pulse on entry to ALARM
//   led         out  sweep pattern
// Same-cycle command priority: ack > load > pause > start.
// ---------------------------------------------------------------------------
module countdown_alarm_timer
    import countdown_alarm_pkg::*;
#(
    parameter int CLKS_PER_SEC = 100000000,
    parameter int CNT_W        = 16,
    parameter int N_LEDS       = 8,
    parameter int SWEEP_CLKS   = 16777216,
    parameter int ALARM_SECS   = 30
) (
    input  logic              clk_100mhz,
    input  logic              rst_n,
    input  logic              load,
    input  logic [CNT_W-1:0]  load_val,
    input  logic              start,
    input  logic              pause,
    input  logic              ack,
    input  logic              alarm_en,
    output logic [CNT_W-1:0]  remaining,
    output logic              running,
    output logic              alarm,
    output logic              done_pulse,
    output logic [N_LEDS-1:0] led
);

    localparam int SEC_W  = cnt_w(CLKS_PER_SEC);
    localparam int ASEC_W = cnt_w(ALARM_SECS);

    localparam logic [SEC_W-1:0]  SEC_LAST  = SEC_W'(CLKS_PER_SEC - 1);
    localparam logic [ASEC_W-1:0] ASEC_LAST = ASEC_W'((ALARM_SECS > 0) ? ALARM_SECS - 1 : 0);

    logic [STATE_W-1:0] state_q, state_d;
    logic [CNT_W-1:0]   rem_q,   rem_d;
    logic [SEC_W-1:0]   sec_q,   sec_d;
    logic [SEC_W-1:0]   asub_q,  asub_d;
    logic [ASEC_W-1:0]  asec_q,  asec_d;
    logic               running_q, alarm_q, done_q, done_d;
    logic               tick;
    logic               sweep_en, sweep_restart;

    assign tick = (state_q == ST_RUN) && (sec_q == SEC_LAST);

    always_comb begin
        state_d = state_q;
        rem_d   = rem_q;
        sec_d   = sec_q;
        asub_d  = '0;
        asec_d  = '0;
        done_d  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                // ack has nothing to abort here but still masks load/start.
                if (ack) begin
                    state_d = ST_IDLE;
                end else if (load) begin
                    rem_d = load_val;
                    sec_d = '0;
                end else if (start && (rem_q != '0)) begin
                    state_d = ST_RUN;
                    sec_d   = '0;
                end
            end

            ST_RUN: begin
                if (ack) begin
                    state_d = ST_IDLE;
                    rem_d   = '0;
                    sec_d   = '0;
                end else if (load) begin
                    // A reload restarts the current second; any tick due
                    // this cycle is dropped.
                    rem_d = load_val;
                    sec_d = '0;
                    if (load_val == '0) begin
                        state_d = ST_IDLE;
                    end
                end else begin
                    sec_d = tick ? '0 : sec_q + 1'b1;
                    if (tick) begin
                        rem_d = rem_q - 1'b1;
                        if (rem_q == CNT_W'(1)) begin
                            state_d = ST_ALARM;
                            done_d  = 1'b1;
                        end
                    end
                    // The final tick wins over a same-cycle pause.
                    if (pause && (state_d == ST_RUN)) begin
                        state_d = ST_PAUSED;
                    end
                end
            end

            ST_PAUSED: begin
                if (ack) begin
                    state_d = ST_IDLE;
                    rem_d   = '0;
                    sec_d   = '0;
                end else if (load) begin
                    rem_d = load_val;
                    sec_d = '0;
                end else if (pause) begin
                    state_d = ST_PAUSED;
                end else if (start && (rem_q != '0)) begin
                    // Resume keeps the partial second already counted.
                    state_d = ST_RUN;
                end
            end

            ST_ALARM: begin
                if (ack) begin
                    state_d = ST_IDLE;
                end else if (ALARM_SECS != 0) begin
                    // Own prescaler so the auto-silence timing does not
                    // depend on the (idle) countdown prescaler.
                    if (asub_q == SEC_LAST) begin
                        asub_d = '0;
                        asec_d = asec_q + 1'b1;
                        if (asec_q == ASEC_LAST) begin
                            state_d = ST_IDLE;
                            asec_d  = '0;
                        end
                    end else begin
                        asub_d = asub_q + 1'b1;
                        asec_d = asec_q;
                    end
                end
            end

            default: begin
                state_d = ST_IDLE;
                rem_d   = '0;
                sec_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk_100mhz) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            rem_q     <= '0;
            sec_q     <= '0;
            asub_q    <= '0;
            asec_q    <= '0;
            running_q <= 1'b0;
            alarm_q   <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            rem_q     <= rem_d;
            sec_q     <= sec_d;
            asub_q    <= asub_d;
            asec_q    <= asec_d;
            running_q <= (state_d == ST_RUN);
            alarm_q   <= (state_d == ST_ALARM);
            done_q    <= done_d;
        end
    end

    // Sweeper is driven from the next state so its registered led output
    // changes on the same edge as alarm.
    assign sweep_en      = (state_d == ST_ALARM);
    assign sweep_restart = (state_d == ST_ALARM) && (state_q != ST_ALARM);

    led_sweeper #(
        .N_LEDS     (N_LEDS),
        .SWEEP_CLKS (SWEEP_CLKS)
    ) u_sweeper (
        .clk_100mhz (clk_100mhz),
        .rst_n      (rst_n),
        .en         (sweep_en),
        .restart    (sweep_restart),
        .show       (alarm_en),
        .led        (led)
    );

    assign remaining  = rem_q;
    assign running    = running_q;
    assign alarm      = alarm_q;
    assign done_pulse = done_q;

endmodule

// File: tb/tb_countdown_alarm_timer.sv
module tb_countdown_alarm_timer;

    localparam int CPS   = 4;
    localparam int SWP   = 2;
    localparam int NL    = 8;
    localparam int ASECS = 3;
    localparam int CW    = 8;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          load = 1'b0;
    logic [CW-1:0] load_val = '0;
    logic          start = 1'b0;
    logic          pause = 1'b0;
    logic          ack = 1'b0;
    logic          alarm_en = 1'b1;
    logic [CW-1:0] remaining;
    logic          running;
    logic          alarm;
    logic          done_pulse;
    logic [NL-1:0] led;

    int n_checks = 0;
    int n_err    = 0;

    always #5 clk = ~clk;

    countdown_alarm_timer #(
        .CLKS_PER_SEC (CPS),
        .CNT_W        (CW),
        .N_LEDS       (NL),
        .SWEEP_CLKS   (SWP),
        .ALARM_SECS   (ASECS)
    ) dut (
        .clk_100mhz (clk),
        .rst_n      (rst_n),
        .load       (load),
        .load_val   (load_val),
        .start      (start),
        .pause      (pause),
        .ack        (ack),
        .alarm_en   (alarm_en),
        .remaining  (remaining),
        .running    (running),
        .alarm      (alarm),
        .done_pulse (done_pulse),
        .led        (led)
    );

    // Expected sweep pattern t cycles after alarm entry: the window steps
    // every SWP cycles over positions 6,5,..,0,1,..,5 and repeats.
    function automatic logic [7:0] sweep_pat(input int t);
        int s;
        logic [7:0] b;
        s = (t / SWP) % (2 * (NL - 2));
        b = 8'b0000_0011;
        return (s <= NL - 2) ? (b << (NL - 2 - s)) : (b << (s - (NL - 2)));
    endfunction

    task automatic tick_clk();
        @(posedge clk);
        #1;
    endtask

    task automatic do_load(input logic [CW-1:0] v);
        load = 1'b1; load_val = v;
        tick_clk();
        load = 1'b0;
    endtask

    task automatic do_start();
        start = 1'b1;
        tick_clk();
        start = 1'b0;
    endtask

    task automatic do_ack();
        ack = 1'b1;
        tick_clk();
        ack = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        tick_clk();
        tick_clk();
        n_checks++; if (remaining !== 8'd0) begin n_err++; $display("FAIL rst_rem got=%0d want=0", remaining); end
        n_checks++; if (running !== 1'b0) begin n_err++; $display("FAIL rst_running got=%b want=0", running); end
        n_checks++; if (alarm !== 1'b0) begin n_err++; $display("FAIL rst_alarm got=%b want=0", alarm); end
        n_checks++; if (done_pulse !== 1'b0) begin n_err++; $display("FAIL rst_done got=%b want=0", done_pulse); end
        n_checks++; if (led !== 8'h00) begin n_err++; $display("FAIL rst_led got=%h want=00", led); end
        rst_n = 1'b1;
        tick_clk();
    endtask

    task automatic test_countdown();
        int er;
        do_load(8'd3);
        do_start();  // edge k
        n_checks++; if (running !== 1'b1) begin n_err++; $display("FAIL cd_run_k got=%b want=1", running); end
        n_checks++; if (remaining !== 8'd3) begin n_err++; $display("FAIL cd_rem_k got=%0d want=3", remaining); end
        for (int j = 1; j <= 13; j++) begin
            tick_clk();
            er = (j >= 12) ? 0 : 3 - j / CPS;
            n_checks++; if (remaining !== CW'(er)) begin n_err++; $display("FAIL cd_rem k+%0d got=%0d want=%0d", j, remaining, er); end
            n_checks++; if (alarm !== (j >= 12)) begin n_err++; $display("FAIL cd_alarm k+%0d got=%b want=%b", j, alarm, (j >= 12)); end
            n_checks++; if (done_pulse !== (j == 12)) begin n_err++; $display("FAIL cd_done k+%0d got=%b want=%b", j, done_pulse, (j == 12)); end
            n_checks++; if (running !== (j < 12)) begin n_err++; $display("FAIL cd_running k+%0d got=%b want=%b", j, running, (j < 12)); end
        end
        do_ack();
        n_checks++; if (alarm !== 1'b0) begin n_err++; $display("FAIL cd_ack_alarm got=%b want=0", alarm); end
    endtask

    task automatic test_pause();
        do_load(8'd3);
        do_start();               // edge k
        repeat (5) tick_clk();    // after edge k+5
        pause = 1'b1;
        tick_clk();               // edge k+6
        pause = 1'b0;
        n_checks++; if (running !== 1'b0) begin n_err++; $display("FAIL pz_running got=%b want=0", running); end
        for (int i = 0; i < 10; i++) begin
            tick_clk();
            n_checks++; if (remaining !== 8'd2) begin n_err++; $display("FAIL pz_hold c%0d got=%0d want=2", i, remaining); end
        end
        do_start();               // RUN re-entry edge m
        n_checks++; if (running !== 1'b1) begin n_err++; $display("FAIL pz_resume got=%b want=1", running); end
        tick_clk();
        n_checks++; if (remaining !== 8'd2) begin n_err++; $display("FAIL pz_m1 got=%0d want=2", remaining); end
        tick_clk();
        n_checks++; if (remaining !== 8'd1) begin n_err++; $display("FAIL pz_m2 got=%0d want=1", remaining); end
        do_ack();
        n_checks++; if (remaining !== 8'd0) begin n_err++; $display("FAIL pz_abort got=%0d want=0", remaining); end
    endtask

    task automatic test_sweep();
        logic en_now;
        alarm_en = 1'b1;
        do_load(8'd1);
        do_start();
        repeat (3) tick_clk();
        for (int t = 0; t < CPS * ASECS; t++) begin
            en_now = !(t == 4 || t == 5);
            alarm_en = en_now;
            tick_clk();
            n_checks++; if (alarm !== 1'b1) begin n_err++; $display("FAIL sw_alarm t=%0d got=%b want=1", t, alarm); end
            n_checks++; if (led !== (en_now ? sweep_pat(t) : 8'h00)) begin n_err++; $display("FAIL sw_led t=%0d got=%h want=%h", t, led, (en_now ? sweep_pat(t) : 8'h00)); end
        end
        alarm_en = 1'b1;
        tick_clk();
        n_checks++; if (led !== 8'h00) begin n_err++; $display("FAIL sw_exit_led got=%h want=00", led); end
        // Fully blanked alarm
        alarm_en = 1'b0;
        do_load(8'd1);
        do_start();
        repeat (4) tick_clk();
        for (int i = 0; i < 3; i++) begin
            n_checks++; if (alarm !== 1'b1 || led !== 8'h00) begin n_err++; $display("FAIL sw_blank c%0d alarm=%b led=%h want alarm=1 led=00", i, alarm, led); end
            tick_clk();
        end
        do_ack();
        alarm_en = 1'b1;
    endtask

    task automatic test_auto_silence();
        int cnt;
        do_load(8'd1);
        do_start();
        repeat (4) tick_clk();
        n_checks++; if (alarm !== 1'b1) begin n_err++; $display("FAIL as_entry got=%b want=1", alarm); end
        cnt = 0;
        while (alarm === 1'b1 && cnt < 40) begin
            tick_clk();
            cnt++;
        end
        n_checks++; if (cnt != CPS * ASECS) begin n_err++; $display("FAIL as_len got=%0d want=%0d", cnt, CPS * ASECS); end
        n_checks++; if (led !== 8'h00 || running !== 1'b0) begin n_err++; $display("FAIL as_idle led=%h running=%b want 00/0", led, running); end
        do_load(8'd1);
        do_start();
        repeat (7) tick_clk();
        n_checks++; if (alarm !== 1'b1) begin n_err++; $display("FAIL as_alarm2 got=%b want=1", alarm); end
        do_ack();
        n_checks++; if (alarm !== 1'b0 || led !== 8'h00) begin n_err++; $display("FAIL as_ack alarm=%b led=%h want 0/00", alarm, led); end
    endtask

    task automatic test_priority();
        do_load(8'd5);
        do_start();
        repeat (2) tick_clk();
        ack = 1'b1; load = 1'b1; start = 1'b1; load_val = 8'd9;
        tick_clk();
        ack = 1'b0; load = 1'b0; start = 1'b0;
        n_checks++; if (running !== 1'b0 || remaining !== 8'd0) begin n_err++; $display("FAIL pr_ack running=%b rem=%0d want 0/0", running, remaining); end
        do_start();
        n_checks++; if (running !== 1'b0) begin n_err++; $display("FAIL pr_start0 got=%b want=0", running); end
        do_load(8'd4);
        do_start();
        tick_clk();
        load = 1'b1; load_val = 8'd7; pause = 1'b1;
        tick_clk();
        load = 1'b0; pause = 1'b0;
        n_checks++; if (running !== 1'b1 || remaining !== 8'd7) begin n_err++; $display("FAIL pr_load_pause running=%b rem=%0d want 1/7", running, remaining); end
        pause = 1'b1; start = 1'b1;
        tick_clk();
        pause = 1'b0; start = 1'b0;
        n_checks++; if (running !== 1'b0) begin n_err++; $display("FAIL pr_pause_start got=%b want=0", running); end
        do_ack();
    endtask

    task automatic test_reset_mid_alarm();
        do_load(8'd1);
        do_start();
        repeat (6) tick_clk();
        rst_n = 1'b0;
        tick_clk();
        n_checks++; if ({remaining, running, alarm, done_pulse, led} !== '0) begin n_err++; $display("FAIL mr_outputs rem=%0d run=%b al=%b dn=%b led=%h want all 0", remaining, running, alarm, done_pulse, led); end
        rst_n = 1'b1;
        do_load(8'd5);
        do_start();
        repeat (4) tick_clk();
        n_checks++; if (remaining !== 8'd4 || running !== 1'b1) begin n_err++; $display("FAIL mr_k4 rem=%0d run=%b want 4/1", remaining, running); end
        repeat (16) tick_clk();
        n_checks++; if (remaining !== 8'd0 || alarm !== 1'b1 || done_pulse !== 1'b1) begin n_err++; $display("FAIL mr_k20 rem=%0d al=%b dn=%b want 0/1/1", remaining, alarm, done_pulse); end
        do_ack();
    endtask

    // Behavioural model: time is tracked as cycles elapsed in the current
    // second and cycles elapsed since alarm entry.
    task automatic test_random();
        typedef enum int {M_IDLE, M_RUN, M_PAUSED, M_ALARM} mode_t;
        mode_t m;
        int m_rem, m_phase, m_at;
        logic m_done;
        logic [7:0] m_led;
        rst_n = 1'b0;
        tick_clk();
        rst_n = 1'b1;
        m = M_IDLE; m_rem = 0; m_phase = 0; m_at = 0;
        for (int c = 0; c < 600; c++) begin
            load     = ($urandom_range(15) == 0);
            load_val = CW'($urandom_range(3));
            start    = ($urandom_range(3) == 0);
            pause    = ($urandom_range(11) == 0);
            ack      = ($urandom_range(39) == 0);
            alarm_en = ($urandom_range(7) != 0);
            m_done = 1'b0;
            case (m)
                M_IDLE: begin
                    if (ack) begin end
                    else if (load) m_rem = int'(load_val);
                    else if (start && m_rem != 0) begin m = M_RUN; m_phase = 0; end
                end
                M_RUN: begin
                    if (ack) begin m = M_IDLE; m_rem = 0; end
                    else if (load) begin
                        m_rem = int'(load_val); m_phase = 0;
                        if (m_rem == 0) m = M_IDLE;
                    end else begin
                        m_phase++;
                        if (m_phase == CPS) begin
                            m_phase = 0;
                            m_rem--;
                            if (m_rem == 0) begin m = M_ALARM; m_at = 0; m_done = 1'b1; end
                        end
                        if (pause && m == M_RUN) m = M_PAUSED;
                    end
                end
                M_PAUSED: begin
                    if (ack) begin m = M_IDLE; m_rem = 0; end
                    else if (load) begin m_rem = int'(load_val); m_phase = 0; end
                    else if (pause) begin end
                    else if (start && m_rem != 0) m = M_RUN;
                end
                default: begin
                    if (ack) m = M_IDLE;
                    else begin
                        m_at++;
                        if (m_at == CPS * ASECS) m = M_IDLE;
                    end
                end
            endcase
            m_led = (m == M_ALARM && alarm_en) ? sweep_pat(m_at) : 8'h00;
            tick_clk();
            n_checks++; if (remaining !== CW'(m_rem)) begin n_err++; $display("FAIL rnd_rem c=%0d got=%0d want=%0d", c, remaining, m_rem); end
            n_checks++; if (running !== (m == M_RUN)) begin n_err++; $display("FAIL rnd_running c=%0d got=%b want=%b", c, running, (m == M_RUN)); end
            n_checks++; if (alarm !== (m == M_ALARM)) begin n_err++; $display("FAIL rnd_alarm c=%0d got=%b want=%b", c, alarm, (m == M_ALARM)); end
            n_checks++; if (done_pulse !== m_done) begin n_err++; $display("FAIL rnd_done c=%0d got=%b want=%b", c, done_pulse, m_done); end
            n_checks++; if (led !== m_led) begin n_err++; $display("FAIL rnd_led c=%0d got=%h want=%h", c, led, m_led); end
        end
        load = 1'b0; start = 1'b0; pause = 1'b0; alarm_en = 1'b1;
        do_ack();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_countdown();
        test_pause();
        test_sweep();
        test_auto_silence();
        test_priority();
        test_reset_mid_alarm();
        test_random();
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
